// File: rtl/serial_adder_sub.sv
// rtl/serial_adder_sub.sv - bit-serial adder/subtractor, LSB-first, one bit per clock
// One full-adder slice plus carry flop; subtraction is a + ~b + 1.
module serial_adder_sub #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_c_msb;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic             w_load;
  logic             w_last;
  logic             w_s;
  logic             w_c;

  // start is honoured whenever the slice is not mid-operation (IDLE or DONE)
  assign w_load = start && (r_state != S_RUN);
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_s    = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_c    = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_op_a  <= a;
      r_op_b  <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_op_a  <= r_op_a >> 1;
      r_op_b  <= r_op_b >> 1;
      r_carry <= w_c;
      r_res   <= {w_s, r_res[WIDTH-1:1]};
      r_cnt   <= r_cnt + CW'(1);
      // carry out of bit WIDTH-2 is the carry into the MSB, needed for overflow
      if (r_cnt == CW'(WIDTH - 2)) r_c_msb <= w_c;
      if (w_last) begin
        r_sum  <= {w_s, r_res[WIDTH-1:1]};
        r_cout <= w_c;
        r_ovf  <= r_c_msb ^ w_c;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
